// File: rtl/mips_defs.sv
// Shared encodings for the MEM-stage data memory responder.
// Access size codes match the size_i field driven from EX/MEM.
// FSM state codes are 2 bits wide.
package mips_defs;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } dmem_state_e;

endpackage

// File: rtl/dmem_subword_align.sv
// Purpose: lane merge for byte/half stores and lane extract/extend for loads (little-endian).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the merged word or extracted data is used.
module dmem_subword_align
  import mips_defs::*;
(
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Load path: pick the addressed lane and zero/sign-extend; size 11 behaves as a word.
  always_comb begin
    rbyte   = rword_i[{off_i, 3'b000} +: 8];
    rhalf   = off_i[1] ? rword_i[31:16] : rword_i[15:0];
    rdata_o = rword_i;
    case (size_i)
      SZ_BYTE: rdata_o = {{24{sign_i & rbyte[7]}}, rbyte};
      SZ_HALF: rdata_o = {{16{sign_i & rhalf[15]}}, rhalf};
      default: rdata_o = rword_i;
    endcase
  end

  // Store path: overwrite only the addressed lane of the current word, keep the others.
  always_comb begin
    wword_o = rword_i;
    case (size_i)
      SZ_BYTE: wword_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: begin
        if (off_i[1]) wword_o[31:16] = wdata_i[15:0];
        else          wword_o[15:0]  = wdata_i[15:0];
      end
      default: wword_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Purpose: MEM-stage data memory; one load/store per instruction, optional sub-word lanes (DMEM_SUBWORD_EN).
// Latency: request cycle + LATENCY wait cycles stalled; load data valid in the following non-stalled cycle.
// Backpressure: stall_o freezes the upstream pipeline for exactly LATENCY+1 cycles per access.
module dmem_responder
  import mips_defs::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2   // legal range 1..15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] rdata_o,
  output logic        stall_o
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  dmem_state_e        state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  idx_q;
  logic [1:0]         off_q;
  logic [31:0]        wdata_q;
  logic               store_q;
  logic [1:0]         size_q;
  logic               sign_q;
  logic [31:0]        rdata_q;

  logic [31:0]        mem [0:2**ADDR_W-1];

  logic               req;
  logic               accept;
  logic               fire;
  logic [31:0]        rword;
  logic [31:0]        store_word;
  logic [31:0]        load_word;

  assign req     = MemRead_i | MemWrite_i;
  assign accept  = (state_q == ST_IDLE) && req;
  // The access completes on the edge that ends the last wait cycle.
  assign fire    = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign rword   = mem[idx_q];
  assign rdata_o = rdata_q;

`ifdef DMEM_SUBWORD_EN
  dmem_subword_align u_align (
    .size_i  (size_q),
    .sign_i  (sign_q),
    .off_i   (off_q),
    .wdata_i (wdata_q),
    .rword_i (rword),
    .wword_o (store_word),
    .rdata_o (load_word)
  );

  logic unused_ok;
  assign unused_ok = ^addr_i[31:ADDR_W+2];
`else
  assign store_word = wdata_q;
  assign load_word  = rword;

  // Full-word build: lane offset, size and sign are carried but not consulted.
  logic unused_ok;
  assign unused_ok = ^{addr_i[31:ADDR_W+2], off_q, size_q, sign_q};
`endif

  // Next-state, wait counter and stall; stall is combinational so the request cycle already stalls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          stall_o = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_o = 1'b1;
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = ST_DONE;
      end
      // DONE ignores req: the same instruction is still held in EX/MEM.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request in IDLE only; later input changes cannot disturb an access in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      off_q   <= 2'b00;
      wdata_q <= 32'h0;
      store_q <= 1'b0;
      size_q  <= SZ_WORD;
      sign_q  <= 1'b0;
    end else if (accept) begin
      idx_q   <= addr_i[ADDR_W+1:2];
      off_q   <= addr_i[1:0];
      wdata_q <= wdata_i;
      store_q <= MemWrite_i;   // read+write together counts as a store
      size_q  <= size_i;
      sign_q  <= sign_i;
    end
  end

  // Load result register: only a completed load changes it.
  always_ff @(posedge clk_i) begin
    if (rst_i)                 rdata_q <= 32'h0;
    else if (fire && !store_q) rdata_q <= load_word;
  end

  // Array write; a reset landing on the completion edge abandons the store.
  always_ff @(posedge clk_i) begin
    if (!rst_i && fire && store_q) mem[idx_q] <= store_word;
  end

endmodule
